// File: rtl/z80_bus_arbiter_if.sv
// rtl/z80_bus_arbiter_if.sv - CPU, DMA and memory port bundle for the tv80s bus arbiter
interface z80_bus_arbiter_if;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n;
  logic        cpu_wr_n;
  logic        cpu_busak_n;
  logic        cpu_busrq_n;

  logic        dma_req;
  logic [15:0] dma_a;
  logic [7:0]  dma_do;
  logic        dma_wr;
  logic        dma_gnt;
  logic        dma_expired;

  logic [15:0] mem_a;
  logic [7:0]  mem_do;
  logic        mem_we;

  modport master (
    input  cpu_a, cpu_do, cpu_mreq_n, cpu_wr_n, cpu_busak_n,
    input  dma_req, dma_a, dma_do, dma_wr,
    output cpu_busrq_n, dma_gnt, dma_expired,
    output mem_a, mem_do, mem_we
  );

  modport slave (
    output cpu_a, cpu_do, cpu_mreq_n, cpu_wr_n, cpu_busak_n,
    output dma_req, dma_a, dma_do, dma_wr,
    input  cpu_busrq_n, dma_gnt, dma_expired,
    input  mem_a, mem_do, mem_we
  );
endinterface

// File: rtl/z80_bus_arbiter.sv
// rtl/z80_bus_arbiter.sv - BUSRQ/BUSAK arbiter sharing tv80s memory with one DMA requester
// DMA tenure is capped at HOLD_MAX cycles and followed by MIN_CPU forced CPU cycles.
module z80_bus_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int MIN_CPU  = 4
) (
  input logic               clk,
  input logic               reset_n,
  z80_bus_arbiter_if.master bus
);

  localparam logic [7:0] HOLD_LIM  = 8'(HOLD_MAX);
  localparam logic [7:0] COOL_INIT = 8'(MIN_CPU);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_RELEASE,
    ST_COOL
  } state_t;

  state_t     state_q, state_d;
  logic       busrq_n_q, busrq_n_d;
  logic       gnt_q, gnt_d;
  logic       exp_q, exp_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] cool_q, cool_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      busrq_n_q <= 1'b1;
      gnt_q     <= 1'b0;
      exp_q     <= 1'b0;
      hold_q    <= 8'd0;
      cool_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      busrq_n_q <= busrq_n_d;
      gnt_q     <= gnt_d;
      exp_q     <= exp_d;
      hold_q    <= hold_d;
      cool_q    <= cool_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    busrq_n_d = busrq_n_q;
    gnt_d     = gnt_q;
    exp_d     = 1'b0;
    hold_d    = hold_q;
    cool_d    = cool_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.dma_req) begin
          state_d   = ST_REQ;
          busrq_n_d = 1'b0;
        end
      end
      ST_REQ: begin
        // A request withdrawn in the same cycle BUSAK arrives is an abort, not a grant.
        if (!bus.dma_req) begin
          state_d   = ST_RELEASE;
          busrq_n_d = 1'b1;
        end else if (!bus.cpu_busak_n) begin
          state_d = ST_GRANT;
          gnt_d   = 1'b1;
          hold_d  = 8'd1;
        end
      end
      ST_GRANT: begin
        if (!bus.dma_req || hold_q == HOLD_LIM) begin
          state_d   = ST_RELEASE;
          gnt_d     = 1'b0;
          busrq_n_d = 1'b1;
          exp_d     = bus.dma_req;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        if (bus.cpu_busak_n) begin
          if (COOL_INIT == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COOL;
            cool_d  = COOL_INIT;
          end
        end
      end
      ST_COOL: begin
        cool_d = cool_q - 8'd1;
        if (cool_q <= 8'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.cpu_busrq_n = busrq_n_q;
  assign bus.dma_gnt     = gnt_q;
  assign bus.dma_expired = exp_q;

  // CPU strobes pass straight through whenever the DMA does not own memory.
  always_comb begin
    if (gnt_q) begin
      bus.mem_a  = bus.dma_a;
      bus.mem_do = bus.dma_do;
      bus.mem_we = bus.dma_wr;
    end else begin
      bus.mem_a  = bus.cpu_a;
      bus.mem_do = bus.cpu_do;
      bus.mem_we = ~bus.cpu_wr_n & ~bus.cpu_mreq_n;
    end
  end

endmodule

// File: doc/z80_bus_arbiter.md
# z80_bus_arbiter

Shares the tv80s system memory (64 KiB, byte-wide) between the CPU and one DMA requester. Uses the Z80 BUSRQ/BUSAK handshake to take the bus from the CPU, steers the memory address, data and write strobes to the current owner, and bounds DMA tenure with a hold limit plus a guaranteed CPU cooldown. It sits between `tv80s` and the memory model/RAM in the system top level.

## Interface
- `HOLD_MAX`, 16: max consecutive grant cycles per DMA tenure (1..255).
- `MIN_CPU`, 4: CPU-owned cycles forced after each release before a new request (0..255).

- `clk` in 1: system clock, same clock as the CPU.
- `reset_n` in 1: synchronous, active-low reset.
- `cpu_a` in 16, `cpu_do` in 8, `cpu_mreq_n` in 1, `cpu_wr_n` in 1: CPU bus outputs.
- `cpu_busak_n` in 1: CPU bus acknowledge.
- `cpu_busrq_n` out 1: bus request to CPU, registered.
- `dma_req` in 1: DMA wants the bus (level).
- `dma_a` in 16, `dma_do` in 8, `dma_wr` in 1: DMA bus, valid only while `dma_gnt`=1.
- `dma_gnt` out 1: DMA owns memory, registered.
- `dma_expired` out 1: one-cycle pulse when a tenure ends on `HOLD_MAX`.
- `mem_a` out 16, `mem_do` out 8, `mem_we` out 1: memory port.

## Operation
- States: IDLE, REQ, GRANT, RELEASE, COOL. Encoding is free.
- IDLE: `dma_req`=1 -> REQ, `cpu_busrq_n`<=0.
- REQ: `dma_req`=0 -> RELEASE, `cpu_busrq_n`<=1 (abort). Else `cpu_busak_n`=0 -> GRANT, `dma_gnt`<=1, hold counter <=1.
- GRANT: if `dma_req`=0, or hold counter == `HOLD_MAX` -> RELEASE with `dma_gnt`<=0 and `cpu_busrq_n`<=1. `dma_expired`<=1 only for the limit case with `dma_req` still 1. Otherwise the hold counter increments (8-bit, never wraps, because the compare fires first).
- RELEASE: `cpu_busak_n`=1 -> COOL, cooldown counter <=`MIN_CPU`. If `MIN_CPU`=0 -> IDLE directly.
- COOL: decrement each cycle. At 1 -> IDLE. `dma_req` is ignored while in COOL.
- Mux, combinational on the registered `dma_gnt`:
  - `dma_gnt`=1: `mem_a`=`dma_a`, `mem_do`=`dma_do`, `mem_we`=`dma_wr`.
  - `dma_gnt`=0: `mem_a`=`cpu_a`, `mem_do`=`cpu_do`, `mem_we`=~`cpu_wr_n` & ~`cpu_mreq_n`.
- CPU writes are never gated by the arbiter in any state. The CPU floats its strobes itself while `cpu_busak_n`=0.
- Simultaneous `dma_req` fall and hold limit in GRANT: a normal release, no `dma_expired`.
- `cpu_busak_n` falling in the same cycle `dma_req` falls in REQ: the abort wins, and no grant is given.

## Timing
- Reset (`reset_n`=0 at a rising edge): state IDLE, `cpu_busrq_n`=1, `dma_gnt`=0, `dma_expired`=0, both counters 0. Applies mid-tenure as well. The mux returns to the CPU in the cycle after that edge.
- Request latency: `dma_req` high before edge N -> `cpu_busrq_n` low after N.
- Grant latency: `cpu_busak_n` low sampled at edge M -> `dma_gnt` high after M.
- Tenure: `dma_gnt` stays high for at most `HOLD_MAX` cycles.
- Release latency: `dma_gnt` and `cpu_busrq_n` change on the same edge.
- Earliest re-request: `MIN_CPU`+1 edges after `cpu_busak_n` returns high.
- `mem_*` outputs are combinational from the inputs and `dma_gnt`. There are no added pipeline stages.

## Test plan
- Reset with `dma_req`=1 held -> `cpu_busrq_n`=1, `dma_gnt`=0 throughout reset. `cpu_busrq_n`=0 on the first edge after `reset_n` rises.
- CPU running `LD (IX+0),D` loop with `dma_req` asserted after 20 cycles -> `dma_gnt`=1 only after `cpu_busak_n`=0. DMA writes 0x5A to 0x8000 -> mem[0x8000]=0x5A. The CPU's writes before the grant land intact.
- `HOLD_MAX`=16, `dma_req` held high -> `dma_gnt` high exactly 16 cycles. `dma_expired` pulses once. Re-grant only after busak rises plus 4 cooldown cycles.
- `dma_req` dropped while in REQ, before busak -> `cpu_busrq_n`=1 next edge, `dma_gnt` never asserts, FSM passes RELEASE and COOL to IDLE.
- `MIN_CPU`=0, back-to-back tenures -> RELEASE goes straight to IDLE. The next `cpu_busrq_n` falls on the edge after `cpu_busak_n` rises.
- `reset_n` pulsed low during GRANT with a DMA write pending -> `dma_gnt`=0 and `mem_we` follows the CPU strobes on the next cycle. No DMA write after that reset edge.
